rr_onehot_arbiter: RTL and testbench

- Four-requester round-robin arbiter.
- Produces a registered one-hot grant vector that feeds the 4-to-2 one-hot encoder stage directly downstream.
- Guarantees the encoder sees only 4'b0000 or exactly one hot bit, never a multi-hot value.
- Holds each grant until the owner signals completion or a watchdog timeout expires.

---
 rtl/rr_onehot_arbiter.sv | 95 +++++++++
 tb/tb_rr_onehot_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_onehot_arbiter.sv
// Four-requester round-robin arbiter with a registered one-hot grant,
// completion-or-watchdog release, and a mandatory idle cycle between grants.
module rr_onehot_arbiter #(
   parameter int N       = 4,
   parameter int TIMEOUT = 15,
   parameter int CW      = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         done,
   output logic [N-1:0] grant,
   output logic         grant_valid,
   output logic         timeout,
   output logic         busy
);

   typedef enum logic {
      IDLE,
      OWN
   } state_e;

   state_e         state_q;
   logic [N-1:0]   grant_q;
   logic           timeout_q;
   logic [CW-1:0]  count_q;
   logic [1:0]     last_q;

   logic [1:0]     sel_d;
   logic           found_d;
   logic [1:0]     cand;

   // Scan upward from the slot after the last owner, so the previous owner is
   // considered last.
   always_comb begin
      sel_d   = 2'd0;
      found_d = 1'b0;
      cand    = 2'd0;
      for (int k = 1; k <= N; k++) begin
         cand = last_q + 2'(k);
         if (!found_d && req[cand]) begin
            sel_d   = cand;
            found_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         timeout_q <= 1'b0;
         count_q   <= '0;
         last_q    <= 2'd3;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (found_d) begin
                  grant_q <= N'(1) << sel_d;
                  last_q  <= sel_d;
                  count_q <= '0;
                  state_q <= OWN;
               end
            end
            OWN: begin
               count_q <= count_q + CW'(1);
               // done takes precedence over an expiring watchdog in the same cycle
               if (done) begin
                  grant_q <= '0;
                  state_q <= IDLE;
               end else if (count_q == CW'(TIMEOUT - 1)) begin
                  grant_q   <= '0;
                  timeout_q <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: begin
               grant_q <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign grant       = grant_q;
   assign grant_valid = |grant_q;
   assign timeout     = timeout_q;
   assign busy        = (state_q == OWN);

   a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
   a_valid_match   : assert property (@(posedge clk) disable iff (rst) grant_valid == |grant);
   a_busy_match    : assert property (@(posedge clk) disable iff (rst) busy == (state_q == OWN));

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter: a cycle-level behavioural model is
// compared every cycle, plus literal expectations at key points.
module tb_rr_onehot_arbiter;

   localparam int TIMEOUT = 15;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       done;
   logic [3:0] grant;
   logic       grantValid;
   logic       timeoutPulse;
   logic       busy;

   int vectors;
   int miscompares;

   rr_onehot_arbiter #(.N(4), .TIMEOUT(TIMEOUT), .CW(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_valid (grantValid),
      .timeout     (timeoutPulse),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: owner index (-1 when nobody holds the grant), cycles the grant has
   // been visible, last served requester, and the watchdog pulse.
   int   mOwner;
   int   mHeld;
   int   mLast;
   logic mTimeout;
   int   mCand;
   logic mFound;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mOwner   = -1;
         mHeld    = 0;
         mLast    = 3;
         mTimeout = 1'b0;
      end else begin
         mTimeout = 1'b0;
         if (mOwner < 0) begin
            mFound = 1'b0;
            for (int k = 1; k <= 4; k++) begin
               mCand = (mLast + k) % 4;
               if (!mFound && req[mCand]) begin
                  mFound = 1'b1;
                  mOwner = mCand;
                  mLast  = mCand;
                  mHeld  = 1;
               end
            end
         end else if (done) begin
            mOwner = -1;
         end else if (mHeld == TIMEOUT) begin
            mOwner   = -1;
            mTimeout = 1'b1;
         end else begin
            mHeld = mHeld + 1;
         end
      end
   end

   function automatic logic [3:0] modelGrant(input int owner);
      logic [3:0] g;
      g = 4'b0000;
      if (owner >= 0) g[owner] = 1'b1;
      return g;
   endfunction

   // Continuous comparison of every output against the model on the falling edge.
   always @(negedge clk) begin
      logic [6:0] expV;
      logic [6:0] actV;
      if (!rst) begin
         expV = {modelGrant(mOwner), (mOwner >= 0), (mOwner >= 0), mTimeout};
         actV = {grant, grantValid, busy, timeoutPulse};
         vectors++;
         if (actV !== expV) begin
            miscompares++;
            $display("[TB] FAIL model t=%0t grant/valid/busy/timeout got=%b required=%b",
                     $time, actV, expV);
         end
      end
   end

   task automatic applyStimulus(input logic [3:0] r, input logic d);
      req  = r;
      done = d;
      @(posedge clk);
      #2;
   endtask

   task automatic checkOutput(input string name, input logic [3:0] expGrant, input logic expTimeout);
      logic [6:0] expV;
      logic [6:0] actV;
      expV = {expGrant, |expGrant, |expGrant, expTimeout};
      actV = {grant, grantValid, busy, timeoutPulse};
      vectors++;
      if (actV !== expV) begin
         miscompares++;
         $display("[TB] FAIL %s grant/valid/busy/timeout got=%b required=%b", name, actV, expV);
      end
   endtask

   function automatic logic [1:0] encode(input logic [3:0] g);
      logic [1:0] e;
      e = 2'b00;
      for (int i = 0; i < 4; i++) if (g[i]) e = 2'(i);
      return e;
   endfunction

   initial begin
      logic [3:0] rrSeq [5];
      vectors     = 0;
      miscompares = 0;
      rst  = 1'b1;
      req  = 4'b0000;
      done = 1'b0;
      rrSeq[0] = 4'b0001;
      rrSeq[1] = 4'b0010;
      rrSeq[2] = 4'b0100;
      rrSeq[3] = 4'b1000;
      rrSeq[4] = 4'b0001;

      applyStimulus(4'b0000, 1'b0);
      applyStimulus(4'b0000, 1'b0);
      checkOutput("reset", 4'b0000, 1'b0);
      rst = 1'b0;

      $display("[TB] single requester with done");
      applyStimulus(4'b0001, 1'b0);
      checkOutput("t1_grant", 4'b0001, 1'b0);
      applyStimulus(4'b0001, 1'b0);
      checkOutput("t1_hold1", 4'b0001, 1'b0);
      applyStimulus(4'b0001, 1'b0);
      checkOutput("t1_hold2", 4'b0001, 1'b0);
      applyStimulus(4'b0000, 1'b1);
      checkOutput("t1_release", 4'b0000, 1'b0);
      vectors++;
      if (encode(grant) !== 2'b00) begin
         miscompares++;
         $display("[TB] FAIL t1_encoder got=%b required=00", encode(grant));
      end

      $display("[TB] full rotation");
      rst = 1'b1;
      applyStimulus(4'b0000, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(4'b1111, 1'b0);
         checkOutput($sformatf("t2_grant%0d", i), rrSeq[i], 1'b0);
         applyStimulus(4'b1111, 1'b1);
         checkOutput($sformatf("t2_gap%0d", i), 4'b0000, 1'b0);
      end

      $display("[TB] wrap-around from owner 1");
      applyStimulus(4'b0010, 1'b0);
      checkOutput("t3_owner1", 4'b0010, 1'b0);
      applyStimulus(4'b0000, 1'b1);
      checkOutput("t3_gap0", 4'b0000, 1'b0);
      applyStimulus(4'b1001, 1'b0);
      checkOutput("t3_pick3", 4'b1000, 1'b0);
      applyStimulus(4'b1001, 1'b1);
      checkOutput("t3_gap1", 4'b0000, 1'b0);
      applyStimulus(4'b1001, 1'b0);
      checkOutput("t3_pick0", 4'b0001, 1'b0);
      applyStimulus(4'b0000, 1'b1);
      checkOutput("t3_gap2", 4'b0000, 1'b0);

      $display("[TB] watchdog expiry");
      applyStimulus(4'b0100, 1'b0);
      checkOutput("t4_grant", 4'b0100, 1'b0);
      for (int i = 1; i < TIMEOUT; i++) begin
         applyStimulus(4'b0100, 1'b0);
         checkOutput($sformatf("t4_hold%0d", i), 4'b0100, 1'b0);
      end
      applyStimulus(4'b0100, 1'b0);
      checkOutput("t4_timeout", 4'b0000, 1'b1);
      applyStimulus(4'b0101, 1'b0);
      checkOutput("t4_skip2", 4'b0001, 1'b0);
      applyStimulus(4'b0000, 1'b1);
      checkOutput("t4_gap", 4'b0000, 1'b0);

      $display("[TB] done coinciding with watchdog, done in idle");
      applyStimulus(4'b0010, 1'b0);
      checkOutput("t5_grant", 4'b0010, 1'b0);
      for (int i = 1; i < TIMEOUT; i++) begin
         applyStimulus(4'b0010, 1'b0);
      end
      checkOutput("t5_lasthold", 4'b0010, 1'b0);
      applyStimulus(4'b0000, 1'b1);
      checkOutput("t5_donewins", 4'b0000, 1'b0);
      applyStimulus(4'b0000, 1'b1);
      checkOutput("t5_idledone", 4'b0000, 1'b0);
      applyStimulus(4'b0000, 1'b0);
      checkOutput("t5_idle", 4'b0000, 1'b0);

      $display("[TB] asynchronous reset mid-grant");
      applyStimulus(4'b0010, 1'b0);
      checkOutput("t6_grant", 4'b0010, 1'b0);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("t6_asyncclear", 4'b0000, 1'b0);
      applyStimulus(4'b0110, 1'b0);
      checkOutput("t6_inreset", 4'b0000, 1'b0);
      rst = 1'b0;
      applyStimulus(4'b0110, 1'b0);
      checkOutput("t6_restart", 4'b0010, 1'b0);
      applyStimulus(4'b0000, 1'b1);
      checkOutput("t6_release", 4'b0000, 1'b0);
      applyStimulus(4'b0000, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
